// File: rtl/boot_loader.sv
// Byte-stream program loader: parses an A5-framed image from the UART side and
// writes it word-by-word into RAM, holding the CPU off the shared bus meanwhile.
module boot_loader #(
  parameter logic [15:0] BASE_ADDR     = 16'h0000,
  parameter int          MAX_WORDS     = 32768,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic        cpu_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  // state   | meaning
  // IDLE    | waiting for 0xA5 sync byte, other bytes dropped
  // LEN_HI  | expecting word count high byte
  // LEN_LO  | expecting word count low byte, range check
  // DATA_HI | expecting data word high byte
  // DATA_LO | expecting data word low byte
  // WRITE   | one-cycle RAM write of the assembled word
  // CSUM    | expecting checksum byte
  // DONE    | good load, release CPU
  // ERR     | failed load, CPU stays held
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CSUM    = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  logic [3:0]  state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] index;
  logic [7:0]  sum;
  logic [7:0]  data_hi;
  logic [7:0]  data_lo;
  logic        hold;
  logic        done;
  logic        err;

  logic        rx_fire;
  logic [15:0] len_next;
  logic        len_too_big;

  assign rx_ready    = (state != S_WRITE) && (state != S_DONE) && (state != S_ERR);
  assign rx_fire     = rx_valid && rx_ready;
  assign len_next    = {len_hi, rx_data};
  assign len_too_big = {16'd0, len_next} > 32'(MAX_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      len_hi  <= 8'd0;
      len     <= 16'd0;
      index   <= 16'd0;
      sum     <= 8'd0;
      data_hi <= 8'd0;
      data_lo <= 8'd0;
      hold    <= HOLD_AT_RESET;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // sum/index cleared here too so a zero-length frame checks against 0
          if (rx_fire && rx_data == 8'hA5) begin
            state <= S_LEN_HI;
            hold  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            sum   <= 8'd0;
            index <= 16'd0;
          end
        end
        S_LEN_HI: begin
          if (rx_fire) begin
            len_hi <= rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (rx_fire) begin
            len <= len_next;
            if (len_next == 16'd0) begin
              state <= S_CSUM;
            end else if (len_too_big) begin
              state <= S_ERR;
            end else begin
              state <= S_DATA_HI;
              index <= 16'd0;
              sum   <= 8'd0;
            end
          end
        end
        S_DATA_HI: begin
          if (rx_fire) begin
            data_hi <= rx_data;
            sum     <= sum + rx_data;
            state   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (rx_fire) begin
            data_lo <= rx_data;
            sum     <= sum + rx_data;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (index + 16'd1 == len) begin
            state <= S_CSUM;
          end else begin
            index <= index + 16'd1;
            state <= S_DATA_HI;
          end
        end
        S_CSUM: begin
          if (rx_fire) begin
            state <= (rx_data == sum) ? S_DONE : S_ERR;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          hold  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          err   <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    if (hold) begin
      mem_addr = BASE_ADDR + index;
      mem_din  = {data_hi, data_lo};
      mem_we   = (state == S_WRITE);
    end else begin
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
      mem_we   = cpu_we;
    end
  end

  assign cpu_hold  = hold;
  assign load_done = done;
  assign load_err  = err;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: frames are driven as byte streams, expected
// RAM writes and load outcomes are queued, and a monitor pops and compares them.
module tb_boot_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  boot_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_we   (cpu_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [2:0] exp_res[$];   // {load_done, load_err, cpu_hold}
  logic [7:0] tx_q[$];

  int vectors = 0;
  int miscompares = 0;
  logic prev_flag = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  // Bytes go out back to back with rx_valid held high; the loader's rx_ready gates them.
  task automatic send_all();
    int guard;
    while (tx_q.size() != 0) begin
      rx_data  = tx_q.pop_front();
      rx_valid = 1'b1;
      guard = 0;
      while (!rx_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) chk("rx_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_results();
    int guard;
    guard = 0;
    while (exp_res.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (exp_res.size() != 0) begin
      chk("result_timeout", 32'(exp_res.size()), 32'd0);
      exp_res.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we && cpu_hold) begin
        chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {mem_addr, mem_din}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("write_addr", {16'd0, mem_addr}, {16'd0, w.addr});
          chk("write_data", {16'd0, mem_din}, {16'd0, w.data});
        end
      end
      if ((load_done || load_err) && !prev_flag) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_result", {29'd0, load_done, load_err, cpu_hold}, 32'h7);
        end else begin
          chk("load_result", {29'd0, load_done, load_err, cpu_hold}, {29'd0, exp_res.pop_front()});
        end
      end
    end
    prev_flag <= load_done || load_err;
  end

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    cpu_addr = 16'h0000;
    cpu_din  = 16'h0000;
    cpu_we   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hold",     {31'd0, cpu_hold},  32'd1);
    chk("reset_done",     {31'd0, load_done}, 32'd0);
    chk("reset_err",      {31'd0, load_err},  32'd0);
    chk("reset_mem_we",   {31'd0, mem_we},    32'd0);
    chk("reset_rx_ready", {31'd0, rx_ready},  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Good two-word frame; 0x12+0x34+0xAB+0xCD = 0x1BE, checksum byte 0xBE
    push_wr(16'h0000, 16'h1234);
    push_wr(16'h0001, 16'hABCD);
    exp_res.push_back(3'b100);
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    send_all();
    wait_results();

    // CPU owns the bus once released
    cpu_addr = 16'h8000;
    cpu_din  = 16'hBEEF;
    cpu_we   = 1'b1;
    #1;
    chk("pass_addr", {16'd0, mem_addr}, 32'h0000_8000);
    chk("pass_din",  {16'd0, mem_din},  32'h0000_BEEF);
    chk("pass_we",   {31'd0, mem_we},   32'd1);
    cpu_we = 1'b0;
    @(negedge clk);

    // Bad checksum: words still land in RAM, CPU stays held
    push_wr(16'h0000, 16'h1234);
    push_wr(16'h0001, 16'hABCD);
    exp_res.push_back(3'b011);
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h17};
    send_all();
    wait_results();

    // While held, cpu_we must not reach memory
    cpu_we = 1'b1;
    #1;
    chk("held_cpu_we_ignored", {31'd0, mem_we}, 32'd0);
    @(negedge clk);

    // Length 0x8001 exceeds MAX_WORDS
    exp_res.push_back(3'b011);
    tx_q = '{8'hA5, 8'h80, 8'h01};
    send_all();
    wait_results();
    cpu_we = 1'b0;

    // Zero-length frame with zero checksum
    exp_res.push_back(3'b100);
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_all();
    wait_results();

    // Reset during the data phase (loader now in DATA_LO)
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12};
    send_all();
    rst_n = 1'b0;
    #1;
    chk("abort_mem_we",   {31'd0, mem_we},    32'd0);
    chk("abort_hold",     {31'd0, cpu_hold},  32'd1);
    chk("abort_done",     {31'd0, load_done}, 32'd0);
    chk("abort_err",      {31'd0, load_err},  32'd0);
    chk("abort_rx_ready", {31'd0, rx_ready},  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-length frame with nonzero checksum
    exp_res.push_back(3'b011);
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h01};
    send_all();
    wait_results();

    // Garbage before sync, A5 inside data; sum A5+01+00+FF+5A+5A = 0x259 -> 0x59
    push_wr(16'h0000, 16'hA501);
    push_wr(16'h0001, 16'h00FF);
    push_wr(16'h0002, 16'h5A5A);
    exp_res.push_back(3'b100);
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h03, 8'hA5, 8'h01, 8'h00, 8'hFF,
             8'h5A, 8'h5A, 8'h59};
    send_all();
    wait_results();

    chk("writes_drained", 32'(exp_wr.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
